// File: rtl/arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_pkg : shared state encodings and owner IDs for the memory bus arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_pick : combinational grant selection between fetch and MEM-stage ports
//            (round-robin tie-break when ARB_RR_EN is defined)
// Rev 1.0
// ---------------------------------------------------------------------------
module arb_pick
  import arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = inst_req | data_req;

`ifdef ARB_RR_EN
  always_comb begin
    grant_owner = OWN_INST;
    if (inst_req && data_req) begin
      // on a tie, the port that did not own the previous transaction wins
      grant_owner = ~last_owner;
    end else if (data_req) begin
      grant_owner = OWN_DATA;
    end
  end
`else
  logic w_unused;
  assign w_unused    = last_owner;
  // the MEM-stage instruction is older, so it always wins a tie
  assign grant_owner = data_req ? OWN_DATA : OWN_INST;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter : shares one split addr/data memory port between fetch and
//                   MEM stage; optional round-robin via macro ARB_RR_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_ack,
  input  logic            data_req,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_ack,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stallreq_if,
  output logic            stallreq_mem
);

  localparam int c_strb_w = DW / 8;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic                  r_owner;
  logic [AW-1:0]         r_addr;
  logic [c_strb_w-1:0]   r_wstrb;
  logic [DW-1:0]         r_wdata;
  logic [DW-1:0]         r_inst_rdata;
  logic [DW-1:0]         r_data_rdata;
  logic                  w_last_owner;
  logic                  w_grant_valid;
  logic                  w_grant_owner;
  logic                  w_take;

  arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .last_owner  (w_last_owner),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  assign w_take = (r_state == ARB_IDLE) && w_grant_valid;

`ifdef ARB_RR_EN
  logic r_last_owner;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_owner <= OWN_INST;
    end else if (w_take) begin
      r_last_owner <= w_grant_owner;
    end
  end
  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = OWN_INST;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // no timeout: the memory side may hold off addr_ok / data_ok indefinitely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant_valid) w_state_nxt = ARB_ADDR;
      ARB_ADDR: if (mem_addr_ok)   w_state_nxt = ARB_WAIT;
      ARB_WAIT: if (mem_data_ok)   w_state_nxt = ARB_RESP;
      ARB_RESP: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWN_INST;
      r_addr       <= '0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_take) begin
        r_owner <= w_grant_owner;
        if (w_grant_owner == OWN_DATA) begin
          r_addr  <= data_addr;
          r_wstrb <= data_wen;
          r_wdata <= data_wdata;
        end else begin
          r_addr  <= inst_addr;
          r_wstrb <= '0;
          r_wdata <= '0;
        end
      end
      // a store completion must not disturb the load-data register
      if ((r_state == ARB_WAIT) && mem_data_ok) begin
        if (r_owner == OWN_INST) begin
          r_inst_rdata <= mem_rdata;
        end else if (r_wstrb == '0) begin
          r_data_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_req      = (r_state == ARB_ADDR);
  assign mem_wr       = |r_wstrb;
  assign mem_wstrb    = r_wstrb;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign inst_rdata   = r_inst_rdata;
  assign data_rdata   = r_data_rdata;
  assign inst_ack     = (r_state == ARB_RESP) && (r_owner == OWN_INST);
  assign data_ack     = (r_state == ARB_RESP) && (r_owner == OWN_DATA);
  assign stallreq_if  = inst_req & ~inst_ack;
  assign stallreq_mem = data_req & ~data_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter : directed bench with a memory model and ack scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_ack;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stallreq_if;
  logic        stallreq_mem;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_ack     (inst_ack),
    .data_req     (data_req),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_ack     (data_ack),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem)
  );

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // memory model controls, written only by the stimulus block
  int addr_delay    = 0;
  int data_delay    = 1;
  int spur_idle_req = 0;
  int spur_addr_req = 0;

  // memory model state, written only by the model
  int          ph = 0;
  int          cnt = 0;
  int          spur_idle_done = 0;
  int          spur_addr_done = 0;
  logic [31:0] lat_addr = '0;
  logic        lat_wr = 1'b0;
  logic [31:0] wr_addr_seen = '0;
  logic [31:0] wr_data_seen = '0;
  logic [3:0]  wr_strb_seen = '0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h3C080001;
      32'h80000010: return 32'hDEADBEEF;
      default:      return a ^ 32'h5A5A1234;
    endcase
  endfunction

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      ph          <= 0;
      cnt         <= 0;
      mem_addr_ok <= 1'b0;
      mem_data_ok <= 1'b0;
      mem_rdata   <= '0;
    end else begin
      mem_addr_ok <= 1'b0;
      mem_data_ok <= 1'b0;
      if (ph == 0) begin
        if (mem_req) begin
          if (cnt == addr_delay) begin
            mem_addr_ok <= 1'b1;
            lat_addr    <= mem_addr;
            lat_wr      <= mem_wr;
            ph          <= 1;
            cnt         <= 0;
            if (mem_wr) begin
              wr_addr_seen <= mem_addr;
              wr_data_seen <= mem_wdata;
              wr_strb_seen <= mem_wstrb;
            end
          end else begin
            cnt <= cnt + 1;
            if (spur_addr_req != spur_addr_done) begin
              mem_data_ok    <= 1'b1;
              spur_addr_done <= spur_addr_done + 1;
            end
          end
        end else if (spur_idle_req != spur_idle_done) begin
          mem_data_ok    <= 1'b1;
          spur_idle_done <= spur_idle_done + 1;
        end
      end else begin
        if (cnt + 1 == data_delay) begin
          mem_data_ok <= 1'b1;
          mem_rdata   <= lat_wr ? 32'h0BADF00D : rd_word(lat_addr);
          ph          <= 0;
          cnt         <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sample point: every ack seen here is matched against the scoreboard
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst && (inst_ack || data_ack)) begin
      chk("ack_excl", 32'(inst_ack & data_ack), 32'd0);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_owner", 32'(data_ack), 32'(e.owner));
        chk("sb_rdata", data_ack ? data_rdata : inst_rdata, e.rdata);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_i;
    logic [31:0] prev_d;
    logic [31:0] first_addr;
    logic        ia;
    logic        da;

    // reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_acks", 32'({inst_ack, data_ack}), 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // single fetch at minimum latency
    inst_req = 1'b1;
    inst_addr = 32'hBFC00000;
    sb.push_back('{OWN_INST, 32'h3C080001});
    for (int c = 0; c <= 3; c++) begin
      tick();
      chk("t1_stall_if", 32'(stallreq_if), 32'(c < 3));
      chk("t1_inst_ack", 32'(inst_ack), 32'(c == 3));
      chk("t1_mem_req", 32'(mem_req), 32'(c == 1));
      if (c == 1) begin
        chk("t1_mem_addr", mem_addr, 32'hBFC00000);
        chk("t1_mem_wr", 32'(mem_wr), 32'd0);
      end
      if (c == 3) chk("t1_inst_rdata", inst_rdata, 32'h3C080001);
    end
    step();
    inst_req = 1'b0;

    // simultaneous requests: data first, inst follows
    step();
    inst_req = 1'b1;
    inst_addr = 32'hBFC00004;
    data_req = 1'b1;
    data_addr = 32'h80000010;
    data_wen = 4'b0000;
    sb.push_back('{OWN_DATA, 32'hDEADBEEF});
    sb.push_back('{OWN_INST, rd_word(32'hBFC00004)});
    for (int c = 0; c <= 7; c++) begin
      tick();
      chk("t2_stall_mem", 32'(stallreq_mem), 32'(c < 3));
      chk("t2_stall_if", 32'(stallreq_if), 32'(c < 7));
      chk("t2_data_ack", 32'(data_ack), 32'(c == 3));
      chk("t2_inst_ack", 32'(inst_ack), 32'(c == 7));
      if (c == 1) chk("t2_addr_data", mem_addr, 32'h80000010);
      if (c == 5) chk("t2_addr_inst", mem_addr, 32'hBFC00004);
      if (c == 3) begin
        step();
        data_req = 1'b0;
      end
      if (c == 7) begin
        step();
        inst_req = 1'b0;
      end
    end

    // partial-word store
    step();
    data_req = 1'b1;
    data_addr = 32'h80000020;
    data_wen = 4'b0011;
    data_wdata = 32'h12345678;
    sb.push_back('{OWN_DATA, 32'hDEADBEEF});
    for (int c = 0; c <= 3; c++) begin
      tick();
      chk("t3_data_ack", 32'(data_ack), 32'(c == 3));
      if (c == 1) begin
        chk("t3_mem_wr", 32'(mem_wr), 32'd1);
        chk("t3_mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("t3_mem_wdata", mem_wdata, 32'h12345678);
        chk("t3_mem_addr", mem_addr, 32'h80000020);
      end
      if (c == 3) chk("t3_data_rdata_kept", data_rdata, 32'hDEADBEEF);
    end
    step();
    data_req = 1'b0;
    data_wen = 4'b0000;
    chk("t3_wr_data_seen", wr_data_seen, 32'h12345678);
    chk("t3_wr_strb_seen", 32'(wr_strb_seen), 32'h3);

    // tie again, previous owner was the data port
    step();
    inst_req = 1'b1;
    inst_addr = 32'hBFC00008;
    data_req = 1'b1;
    data_addr = 32'h80000040;
`ifdef ARB_RR_EN
    first_addr = 32'hBFC00008;
    sb.push_back('{OWN_INST, rd_word(32'hBFC00008)});
    sb.push_back('{OWN_DATA, rd_word(32'h80000040)});
`else
    first_addr = 32'h80000040;
    sb.push_back('{OWN_DATA, rd_word(32'h80000040)});
    sb.push_back('{OWN_INST, rd_word(32'hBFC00008)});
`endif
    for (int c = 0; c < 20 && (inst_req || data_req); c++) begin
      tick();
      if (c == 1) chk("t4_first_addr", mem_addr, first_addr);
      ia = inst_ack;
      da = data_ack;
      if (ia || da) begin
        step();
        if (ia) inst_req = 1'b0;
        if (da) data_req = 1'b0;
      end
    end
    chk("t4_done", 32'({inst_req, data_req}), 32'd0);

    // slow memory: addr_ok after 3 extra cycles, data_ok 5 cycles later
    addr_delay = 3;
    data_delay = 5;
    step();
    data_req = 1'b1;
    data_addr = 32'h80000030;
    sb.push_back('{OWN_DATA, rd_word(32'h80000030)});
    for (int c = 0; c <= 10; c++) begin
      tick();
      chk("t5_stall_mem", 32'(stallreq_mem), 32'(c < 10));
      chk("t5_data_ack", 32'(data_ack), 32'(c == 10));
      chk("t5_mem_req", 32'(mem_req), 32'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk("t5_mem_addr", mem_addr, 32'h80000030);
      if (c == 10) chk("t5_data_rdata", data_rdata, rd_word(32'h80000030));
    end
    step();
    data_req = 1'b0;
    addr_delay = 0;
    data_delay = 1;

    // spurious data_ok in IDLE, then in ADDR
    tick();
    prev_i = inst_rdata;
    prev_d = data_rdata;
    step();
    spur_idle_req = spur_idle_req + 1;
    tick();
    tick();
    chk("t6_idle_no_ack", 32'({inst_ack, data_ack}), 32'd0);
    chk("t6_idle_inst_rdata", inst_rdata, prev_i);
    chk("t6_idle_data_rdata", data_rdata, prev_d);
    addr_delay = 2;
    spur_addr_req = spur_addr_req + 1;
    step();
    inst_req = 1'b1;
    inst_addr = 32'hBFC00010;
    sb.push_back('{OWN_INST, rd_word(32'hBFC00010)});
    for (int c = 0; c <= 5; c++) begin
      tick();
      chk("t6_inst_ack", 32'(inst_ack), 32'(c == 5));
      chk("t6_mem_req", 32'(mem_req), 32'(c >= 1 && c <= 3));
      if (c == 2) chk("t6_addr_rdata_kept", inst_rdata, prev_i);
      if (c == 5) chk("t6_inst_rdata", inst_rdata, rd_word(32'hBFC00010));
    end
    step();
    inst_req = 1'b0;
    addr_delay = 0;

    // asynchronous reset while waiting for data
    data_delay = 4;
    step();
    inst_req = 1'b1;
    inst_addr = 32'hBFC00014;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    inst_req = 1'b0;
    #1;
    chk("t7_mem_req", 32'(mem_req), 32'd0);
    chk("t7_mem_addr", mem_addr, 32'd0);
    chk("t7_inst_rdata", inst_rdata, 32'd0);
    chk("t7_data_rdata", data_rdata, 32'd0);
    chk("t7_misc", 32'({mem_wr, mem_wstrb, inst_ack, data_ack, stallreq_if}), 32'd0);
    sb.delete();
    step();
    step();
    rst = 1'b1;
    data_delay = 1;
    step();
    inst_req = 1'b1;
    inst_addr = 32'hBFC00000;
    sb.push_back('{OWN_INST, 32'h3C080001});
    for (int c = 0; c <= 3; c++) begin
      tick();
      chk("t7_post_ack", 32'(inst_ack), 32'(c == 3));
      if (c == 1) chk("t7_post_addr", mem_addr, 32'hBFC00000);
      if (c == 3) chk("t7_post_rdata", inst_rdata, 32'h3C080001);
    end
    step();
    inst_req = 1'b0;
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the instruction fetch stage and the MEM stage's data access.
- Grants one requester at a time, runs an addr/data split handshake on the memory side, and returns read data plus a one-cycle ack to the owner.
- Drives per-stage stall requests into the pipeline stall controller while an access is outstanding.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- inst_req  in  1  fetch request; held high until inst_ack.
- inst_addr  in  AW  fetch address.
- inst_rdata  out  DW  fetched word.
- inst_ack  out  1  one-cycle completion pulse.
- data_req  in  1  MEM-stage request; held until data_ack.
- data_wen  in  DW/8  byte write strobes; all zero means read.
- data_addr  in  AW  data address.
- data_wdata  in  DW  store data.
- data_rdata  out  DW  load data.
- data_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory-side request valid.
- mem_wr  out  1  1 = write.
- mem_wstrb  out  DW/8  byte strobes.
- mem_addr  out  AW  address.
- mem_wdata  out  DW  write data.
- mem_addr_ok  in  1  memory accepted address this cycle.
- mem_data_ok  in  1  memory read data valid or write done.
- mem_rdata  in  DW  memory read data.
- stallreq_if  out  1  stall request for the fetch stage.
- stallreq_mem  out  1  stall request for the MEM stage.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, owner cleared.
  - All outputs 0, including rdata registers and mem_* signals.
  - An in-flight memory transaction is abandoned; the memory model is reset by the same rst.
- States IDLE, ADDR, WAIT, RESP; 2-bit encoding.
- IDLE:
  - If data_req or inst_req is high, pick the owner.
  - Default priority: data beats inst, because the MEM-stage instruction is older.
  - Latch the owner's addr, wen and wdata into registers.
  - Go to ADDR. Requester inputs are not sampled again until the next IDLE.
- ADDR:
  - mem_req=1 and all mem_* driven from the latched registers. mem_wr = |wstrb.
  - On mem_addr_ok: go to WAIT, and mem_req drops in that cycle's successor.
- WAIT:
  - mem_req=0.
  - On mem_data_ok: if the owner is inst, capture mem_rdata into inst_rdata. If the owner is data and it is a read, capture into data_rdata. A write leaves rdata unchanged.
  - Go to RESP.
- RESP: the owner's ack=1 for exactly one cycle, then go to IDLE.
- Minimum latency from req seen in IDLE at cycle n: ADDR at n+1, addr_ok at n+1, data_ok at n+2, ack at n+3, IDLE at n+4.
- There is no upper bound on wait; the block waits indefinitely for addr_ok or data_ok.
- mem_data_ok in IDLE, ADDR or RESP is ignored; data_ok is never accepted in the same cycle as addr_ok.
- inst_rdata and data_rdata hold their value until the next capture for that port.
- Stall requests are combinational:
  - stallreq_if = inst_req & ~inst_ack.
  - stallreq_mem = data_req & ~data_ack.
- A requester that is not granted keeps its stall asserted across the other port's whole transaction.
- Both acks are never high in the same cycle.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - A 1-bit last_owner register is added, reset to inst.
  - When both requests are high in IDLE, the port that did not own the previous transaction is granted.
  - A single request is granted immediately regardless of last_owner.
- Undefined: fixed data-over-inst priority, and no last_owner register exists.

Decomposition:
- Shared package arb_pkg:
  - State encodings ARB_IDLE, ARB_ADDR, ARB_WAIT, ARB_RESP.
  - Owner constants OWN_INST=0, OWN_DATA=1.
- One natural sub-module, arb_pick:
  - Inputs: inst_req, data_req, last_owner.
  - Outputs: grant_valid, grant_owner.
  - Pure combinational; holds the ARB_RR_EN logic.

Test Plan:
- Reset, then inst_req with inst_addr=0xBFC00000, memory with addr_ok immediate and data_ok 1 cycle later returning 0x3C080001 -> mem_addr=0xBFC00000 at n+1, inst_rdata=0x3C080001 and inst_ack at n+3, stallreq_if high n..n+2.
- inst_req and data_req rise in the same cycle (data read 0x80000010 returning 0xDEADBEEF) -> data served first with data_ack at n+3, inst granted at n+4 with ack at n+7; with ARB_RR_EN and last_owner=data, inst is served first.
- Store with data_wen=4'b0011, data_wdata=0x12345678 -> mem_wr=1, mem_wstrb=0011, mem_wdata=0x12345678; data_ack pulses; data_rdata keeps its prior value.
- Memory stalls: addr_ok delayed 3 cycles and data_ok delayed 5 -> mem_req held stable for 4 cycles with unchanged addr, ack exactly one cycle after data_ok, stallreq_mem continuous.
- Spurious mem_data_ok pulse in IDLE and in ADDR -> no ack, no rdata change, state sequence unaffected.
- rst driven low during WAIT -> outputs go 0 immediately without a clock edge; after release, a new inst_req completes normally at minimum latency.
